// File: rtl/alu_8bit_if.sv
// Operand/select and result/flag bundle for the 8-bit ALU.
//   A, B   : unsigned operands (master -> slave)
//   Sel    : operation select (master -> slave)
//   Su     : registered result (slave -> master)
//   Z,C,S,P: registered zero/carry/sign/even-parity flags (slave -> master)
interface alu_8bit_if;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 4;

    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [SEL_W-1:0]  Sel;
    logic [DATA_W-1:0] Su;
    logic              Z;
    logic              C;
    logic              S;
    logic              P;

    modport master (output A, B, Sel, input Su, Z, C, S, P);
    modport slave  (input A, B, Sel, output Su, Z, C, S, P);
endinterface

// File: rtl/alu_8bit.sv
// 8-bit registered ALU: 16 ops on A/B selected by Sel, result and Z/C/S/P flags
// registered one cycle after the operands are sampled.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears result and all flags
//   bus : alu_8bit_if slave modport (A, B, Sel in; Su, Z, C, S, P out)
module alu_8bit (
    input  logic       clk,
    input  logic       rst,
    alu_8bit_if.slave  bus
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic [SEL_W-1:0] {
        OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_MUL  = 4'h2, OP_DIV  = 4'h3,
        OP_SHL  = 4'h4, OP_SHR  = 4'h5, OP_ROL  = 4'h6, OP_ROR  = 4'h7,
        OP_AND  = 4'h8, OP_OR   = 4'h9, OP_XOR  = 4'hA, OP_NOR  = 4'hB,
        OP_NAND = 4'hC, OP_XNOR = 4'hD, OP_GT   = 4'hE, OP_EQ   = 4'hF
    } op_e;

    logic [DATA_W-1:0]   su_q, su_d;
    logic                z_q, z_d;
    logic                c_q, c_d;
    logic                s_q, s_d;
    logic                p_q, p_d;

    logic [DATA_W:0]     add_full;
    logic [DATA_W:0]     sub_full;
    logic [2*DATA_W-1:0] mul_full;

    // Full-width arithmetic; the extra bits give carry, borrow and overflow.
    assign add_full = (DATA_W+1)'(bus.A) + (DATA_W+1)'(bus.B);
    assign sub_full = (DATA_W+1)'(bus.A) - (DATA_W+1)'(bus.B);
    assign mul_full = (2*DATA_W)'(bus.A) * (2*DATA_W)'(bus.B);

    // Op decode; flags are derived from the same result that gets registered.
    always_comb begin
        su_d = '0;
        c_d  = 1'b0;
        unique case (op_e'(bus.Sel))
            OP_ADD: begin
                su_d = add_full[DATA_W-1:0];
                c_d  = add_full[DATA_W];
            end
            OP_SUB: begin
                su_d = sub_full[DATA_W-1:0];
                c_d  = sub_full[DATA_W];
            end
            OP_MUL: begin
                su_d = mul_full[DATA_W-1:0];
                c_d  = |mul_full[2*DATA_W-1:DATA_W];
            end
            OP_DIV: begin
                // Divide by zero saturates and raises C.
                if (bus.B == '0) begin
                    su_d = '1;
                    c_d  = 1'b1;
                end else begin
                    su_d = bus.A / bus.B;
                end
            end
            OP_SHL: begin
                su_d = {bus.A[DATA_W-2:0], 1'b0};
                c_d  = bus.A[DATA_W-1];
            end
            OP_SHR: begin
                su_d = {1'b0, bus.A[DATA_W-1:1]};
                c_d  = bus.A[0];
            end
            OP_ROL: begin
                su_d = {bus.A[DATA_W-2:0], bus.A[DATA_W-1]};
                c_d  = bus.A[DATA_W-1];
            end
            OP_ROR: begin
                su_d = {bus.A[0], bus.A[DATA_W-1:1]};
                c_d  = bus.A[0];
            end
            OP_AND:  su_d = bus.A & bus.B;
            OP_OR:   su_d = bus.A | bus.B;
            OP_XOR:  su_d = bus.A ^ bus.B;
            OP_NOR:  su_d = ~(bus.A | bus.B);
            OP_NAND: su_d = ~(bus.A & bus.B);
            OP_XNOR: su_d = ~(bus.A ^ bus.B);
            OP_GT:   su_d = DATA_W'(bus.A > bus.B);
            OP_EQ:   su_d = DATA_W'(bus.A == bus.B);
            default: begin
                su_d = '0;
                c_d  = 1'b0;
            end
        endcase
        z_d = (su_d == '0);
        s_d = su_d[DATA_W-1];
        p_d = ~^su_d;
    end

    // Output register stage; reset overrides any op.
    always_ff @(posedge clk) begin
        if (rst) begin
            su_q <= '0;
            z_q  <= 1'b0;
            c_q  <= 1'b0;
            s_q  <= 1'b0;
            p_q  <= 1'b0;
        end else begin
            su_q <= su_d;
            z_q  <= z_d;
            c_q  <= c_d;
            s_q  <= s_d;
            p_q  <= p_d;
        end
    end

    assign bus.Su = su_q;
    assign bus.Z  = z_q;
    assign bus.C  = c_q;
    assign bus.S  = s_q;
    assign bus.P  = p_q;
endmodule

// File: tb/tb_alu_8bit.sv
// Directed bench for alu_8bit: reset, full Sel sweep, arithmetic/shift edge
// cases, input-hold between edges, and reset in the middle of a stream.
module tb_alu_8bit;
    logic clk;
    logic rst;
    int   passed;
    int   total;

    alu_8bit_if bus ();

    alu_8bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
        $fatal(1, "watchdog");
    end

    // Drive inputs, then step to just after the next rising edge.
    task automatic cycle(input logic r, input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        rst     = r;
        bus.A   = a;
        bus.B   = b;
        bus.Sel = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 8'h5A, 8'h33, 4'h0);
        total++;
        if ({bus.Su, bus.Z, bus.C, bus.S, bus.P} !== 12'h000)
            $display("FAIL reset: Su=%h ZCSP=%b%b%b%b expected Su=00 ZCSP=0000",
                     bus.Su, bus.Z, bus.C, bus.S, bus.P);
        else passed++;
    endtask

    task automatic test_sweep();
        logic [7:0]  exp_su [16];
        logic [15:0] exp_z;
        logic [15:0] exp_c;
        logic [15:0] exp_s;
        logic [15:0] exp_p;
        exp_su = '{8'h05, 8'h01, 8'h06, 8'h01, 8'h06, 8'h01, 8'h06, 8'h81,
                   8'h02, 8'h03, 8'h01, 8'hFC, 8'hFD, 8'hFE, 8'h01, 8'h00};
        exp_z  = 16'h8000;
        exp_c  = 16'h00A0;
        exp_s  = 16'h3880;
        exp_p  = 16'h8AD5;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h03, 8'h02, 4'(i));
            total++;
            if (bus.Su !== exp_su[i])
                $display("FAIL sweep_su sel=%0d: Su=%h expected %h", i, bus.Su, exp_su[i]);
            else passed++;
            total++;
            if ({bus.Z, bus.C, bus.S, bus.P} !== {exp_z[i], exp_c[i], exp_s[i], exp_p[i]})
                $display("FAIL sweep_flags sel=%0d: ZCSP=%b%b%b%b expected %b%b%b%b", i,
                         bus.Z, bus.C, bus.S, bus.P, exp_z[i], exp_c[i], exp_s[i], exp_p[i]);
            else passed++;
        end
    endtask

    task automatic test_add_sub();
        cycle(1'b0, 8'hFF, 8'h01, 4'h0);
        total++;
        if ({bus.Su, bus.Z, bus.C, bus.S, bus.P} !== {8'h00, 4'b1101})
            $display("FAIL add_wrap: Su=%h ZCSP=%b%b%b%b expected Su=00 ZCSP=1101",
                     bus.Su, bus.Z, bus.C, bus.S, bus.P);
        else passed++;
        cycle(1'b0, 8'h03, 8'h05, 4'h1);
        total++;
        if ({bus.Su, bus.Z, bus.C, bus.S, bus.P} !== {8'hFE, 4'b0110})
            $display("FAIL sub_borrow: Su=%h ZCSP=%b%b%b%b expected Su=FE ZCSP=0110",
                     bus.Su, bus.Z, bus.C, bus.S, bus.P);
        else passed++;
        cycle(1'b0, 8'h05, 8'h05, 4'h1);
        total++;
        if ({bus.Su, bus.Z, bus.C, bus.S, bus.P} !== {8'h00, 4'b1001})
            $display("FAIL sub_equal: Su=%h ZCSP=%b%b%b%b expected Su=00 ZCSP=1001",
                     bus.Su, bus.Z, bus.C, bus.S, bus.P);
        else passed++;
    endtask

    task automatic test_mul_div();
        cycle(1'b0, 8'h10, 8'h20, 4'h2);
        total++;
        if ({bus.Su, bus.Z, bus.C, bus.S, bus.P} !== {8'h00, 4'b1101})
            $display("FAIL mul_ovf: Su=%h ZCSP=%b%b%b%b expected Su=00 ZCSP=1101",
                     bus.Su, bus.Z, bus.C, bus.S, bus.P);
        else passed++;
        cycle(1'b0, 8'h0F, 8'h11, 4'h2);
        total++;
        if ({bus.Su, bus.Z, bus.C, bus.S, bus.P} !== {8'hFF, 4'b0011})
            $display("FAIL mul_fit: Su=%h ZCSP=%b%b%b%b expected Su=FF ZCSP=0011",
                     bus.Su, bus.Z, bus.C, bus.S, bus.P);
        else passed++;
        cycle(1'b0, 8'h07, 8'h00, 4'h3);
        total++;
        if ({bus.Su, bus.Z, bus.C, bus.S, bus.P} !== {8'hFF, 4'b0111})
            $display("FAIL div_zero: Su=%h ZCSP=%b%b%b%b expected Su=FF ZCSP=0111",
                     bus.Su, bus.Z, bus.C, bus.S, bus.P);
        else passed++;
        cycle(1'b0, 8'hC8, 8'h07, 4'h3);
        total++;
        if ({bus.Su, bus.C} !== {8'h1C, 1'b0})
            $display("FAIL div_norm: Su=%h C=%b expected Su=1C C=0", bus.Su, bus.C);
        else passed++;
    endtask

    task automatic test_shift_rot();
        cycle(1'b0, 8'h80, 8'h00, 4'h4);
        total++;
        if ({bus.Su, bus.Z, bus.C} !== {8'h00, 2'b11})
            $display("FAIL shl_out: Su=%h Z=%b C=%b expected Su=00 Z=1 C=1", bus.Su, bus.Z, bus.C);
        else passed++;
        cycle(1'b0, 8'h01, 8'h00, 4'h5);
        total++;
        if ({bus.Su, bus.Z, bus.C} !== {8'h00, 2'b11})
            $display("FAIL shr_out: Su=%h Z=%b C=%b expected Su=00 Z=1 C=1", bus.Su, bus.Z, bus.C);
        else passed++;
        cycle(1'b0, 8'h81, 8'h00, 4'h6);
        total++;
        if ({bus.Su, bus.C} !== {8'h03, 1'b1})
            $display("FAIL rol_wrap: Su=%h C=%b expected Su=03 C=1", bus.Su, bus.C);
        else passed++;
        cycle(1'b0, 8'h81, 8'h00, 4'h7);
        total++;
        if ({bus.Su, bus.C, bus.S} !== {8'hC0, 2'b11})
            $display("FAIL ror_wrap: Su=%h C=%b S=%b expected Su=C0 C=1 S=1", bus.Su, bus.C, bus.S);
        else passed++;
    endtask

    task automatic test_hold();
        cycle(1'b0, 8'h03, 8'h02, 4'h0);
        bus.A   = 8'h40;
        bus.Sel = 4'h2;
        #3;
        total++;
        if (bus.Su !== 8'h05)
            $display("FAIL hold_between_edges: Su=%h expected 05", bus.Su);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if ({bus.Su, bus.C} !== {8'h80, 1'b0})
            $display("FAIL hold_next_edge: Su=%h C=%b expected Su=80 C=0", bus.Su, bus.C);
        else passed++;
    endtask

    task automatic test_back_to_back();
        cycle(1'b0, 8'h10, 8'h20, 4'h0);
        total++;
        if (bus.Su !== 8'h30)
            $display("FAIL b2b_add: Su=%h expected 30", bus.Su);
        else passed++;
        cycle(1'b1, 8'hFF, 8'h01, 4'h0);
        total++;
        if ({bus.Su, bus.Z, bus.C, bus.S, bus.P} !== 12'h000)
            $display("FAIL b2b_reset: Su=%h ZCSP=%b%b%b%b expected Su=00 ZCSP=0000",
                     bus.Su, bus.Z, bus.C, bus.S, bus.P);
        else passed++;
        cycle(1'b0, 8'h03, 8'h02, 4'h0);
        total++;
        if ({bus.Su, bus.Z, bus.C, bus.S, bus.P} !== {8'h05, 4'b0001})
            $display("FAIL b2b_release: Su=%h ZCSP=%b%b%b%b expected Su=05 ZCSP=0001",
                     bus.Su, bus.Z, bus.C, bus.S, bus.P);
        else passed++;
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        rst     = 1'b1;
        bus.A   = '0;
        bus.B   = '0;
        bus.Sel = '0;
        test_reset();
        test_sweep();
        test_add_sub();
        test_mul_div();
        test_shift_rot();
        test_hold();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
